// File: rtl/jtl_sched_pkg.sv
// Shared types and constants for the JTL pulse scheduler.
// Tracker entries carry requester id and launch timestamp.
package jtl_sched_pkg;

  localparam int ERR_LATE = 1;
  localparam int ERR_SPUR = 0;

  localparam int ID_W = 4;
  localparam int TS_W = 16;

  function automatic int ts_width(int delay, int tol);
    return $clog2(delay + tol + 2) + 1;
  endfunction

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] ts;
  } trk_entry_t;

endpackage

// File: rtl/jtl_track_fifo.sv
// Circular FIFO of in-flight pulse entries.
// Push and pop may coincide, including when full.
module jtl_track_fifo
  import jtl_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  trk_entry_t                 push_data,
  input  logic                       pop,
  output trk_entry_t                 head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  trk_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtl_pulse_sched.sv
// Round-robin launcher for a shared JTL line with
// arrival matching, timeout and spacing control.
module jtl_pulse_sched
  import jtl_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MIN_GAP = 3,
  parameter int DELAY   = 8,
  parameter int TOL     = 1,
  parameter int DEPTH   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic [N_REQ-1:0]                       req,
  output logic [N_REQ-1:0]                       grant,
  output logic                                   jtl_in,
  input  logic                                   jtl_out,
  output logic                                   done_valid,
  output logic [(N_REQ>1?$clog2(N_REQ):1)-1:0]   done_id,
  output logic                                   err_late,
  output logic                                   err_spurious,
  output logic [1:0]                             err_sticky,
  input  logic                                   err_clr,
  output logic                                   busy,
  output logic [$clog2(DEPTH+1)-1:0]             inflight
);

  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AGE_W = ts_width(DELAY, TOL);
  localparam int QW    = $clog2(DELAY + TOL + 2);
  localparam int GW    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int LO    = DELAY - TOL;
  localparam int HI    = DELAY + TOL;
  localparam int TMO   = DELAY + TOL + 1;

  logic [TS_W-1:0]  now;
  logic [QW-1:0]    quiet;
  logic [GW-1:0]    gap;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic             found;
  logic             elig;
  logic             jtl_out_q;
  logic             arrival;
  logic [AGE_W-1:0] age;
  logic             in_win;
  logic             too_old;
  logic             done_n;
  logic             late_n;
  logic             spur_n;
  logic [1:0]       err_set;
  logic             full;
  logic             empty;
  trk_entry_t       head;
  trk_entry_t       push_e;
  logic             unused_id;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  // Full is the count before any pop in this cycle.
  assign elig = enable && (quiet == '0) && (gap == '0)
              && !full && found;

  always_comb begin
    push_e    = '0;
    push_e.id = ID_W'(win);
    push_e.ts = now + 1'b1;
  end

  assign arrival = (jtl_out != jtl_out_q) && (quiet == '0);
  assign age     = AGE_W'(now - head.ts);
  assign in_win  = !empty && (age >= AGE_W'(LO))
                 && (age <= AGE_W'(HI));
  assign too_old = !empty && (age >= AGE_W'(TMO));

  // An arrival on an overdue head is classified as late.
  always_comb begin
    done_n = 1'b0;
    late_n = 1'b0;
    spur_n = 1'b0;
    unique case (1'b1)
      too_old:                       late_n = 1'b1;
      arrival && in_win:             done_n = 1'b1;
      arrival && !in_win && !too_old: spur_n = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    err_set           = '0;
    err_set[ERR_LATE] = late_n;
    err_set[ERR_SPUR] = spur_n;
  end

  assign busy      = (quiet != '0) || (inflight != '0);
  assign unused_id = ^head.id;

  jtl_track_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (elig),
    .push_data (push_e),
    .pop       (done_n || late_n),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (inflight)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      now          <= '0;
      quiet        <= QW'(TMO);
      gap          <= '0;
      ptr          <= '0;
      jtl_in       <= 1'b0;
      jtl_out_q    <= 1'b0;
      grant        <= '0;
      done_valid   <= 1'b0;
      done_id      <= '0;
      err_late     <= 1'b0;
      err_spurious <= 1'b0;
      err_sticky   <= '0;
    end else begin
      now       <= now + 1'b1;
      jtl_out_q <= jtl_out;
      if (quiet != '0) quiet <= quiet - 1'b1;
      grant <= elig ? (N_REQ'(1) << win) : '0;
      if (elig) begin
        jtl_in <= ~jtl_in;
        ptr    <= IW'((int'(win) + 1) % N_REQ);
        gap    <= GW'(MIN_GAP - 1);
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      done_valid   <= done_n;
      if (done_n) done_id <= IW'(head.id);
      err_late     <= late_n;
      err_spurious <= spur_n;
      err_sticky   <= (err_clr ? 2'b00 : err_sticky) | err_set;
    end
  end

endmodule

// File: tb/tb_jtl_pulse_sched.sv
// Scoreboard bench for jtl_pulse_sched: expected events are
// queued by the stimulus and matched by a negedge monitor.
module tb_jtl_pulse_sched;

  localparam int K_GNT  = 0;
  localparam int K_DONE = 1;
  localparam int K_LATE = 2;
  localparam int K_SPUR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] req = 4'b0;
  logic       jtl_out = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] grant;
  logic       jtl_in;
  logic       done_valid;
  logic [1:0] done_id;
  logic       err_late;
  logic       err_spurious;
  logic [1:0] err_sticky;
  logic       busy;
  logic [2:0] inflight;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;
  exp_t q[$];

  jtl_pulse_sched dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req          (req),
    .grant        (grant),
    .jtl_in       (jtl_in),
    .jtl_out      (jtl_out),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .err_late     (err_late),
    .err_spurious (err_spurious),
    .err_sticky   (err_sticky),
    .err_clr      (err_clr),
    .busy         (busy),
    .inflight     (inflight)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic void expect_ev(int c, int k, int v);
    exp_t e;
    int pos;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > c || (q[i].cyc == c && q[i].kind > k)) begin
        pos = i;
        break;
      end
    end
    q.insert(pos, e);
  endfunction

  task automatic drop_missing(int c, int k);
    while (q.size() > 0 && (q[0].cyc < c ||
           (q[0].cyc == c && q[0].kind < k))) begin
      checks++;
      failures++;
      $display("FAIL missing kind=%0d want_cyc=%0d now=%0d",
               q[0].kind, q[0].cyc, cyc);
      void'(q.pop_front());
    end
  endtask

  task automatic mon_one(int k, logic seen, int v);
    drop_missing(cyc, k);
    if (seen) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc || q[0].kind != k) begin
        failures++;
        $display("FAIL unexpected kind=%0d cyc=%0d got=%0d",
                 k, cyc, v);
      end else begin
        if (q[0].val != v) begin
          failures++;
          $display("FAIL value kind=%0d cyc=%0d got=%0d want=%0d",
                   k, cyc, v, q[0].val);
        end
        void'(q.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_one(K_GNT, grant != 4'b0, int'(grant));
      mon_one(K_DONE, done_valid, int'(done_id));
      mon_one(K_LATE, err_late, 0);
      mon_one(K_SPUR, err_spurious, 0);
      drop_missing(cyc + 1, 0);
    end
  end

  task automatic check(string name, int act, int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               name, cyc, act, want);
    end
  endtask

  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    // single pulse
    check("rst_outs", int'({grant, jtl_in, done_valid, err_late,
          err_spurious, err_sticky, inflight, done_id}), 0);
    check("rst_busy", busy, 1);
    at(9);  check("quiet_busy", busy, 1);
    at(10); check("quiet_end", busy, 0);
    req = 4'b0100; expect_ev(11, K_GNT, 4);
    at(11); check("jtl_in", jtl_in, 1); check("infl1", inflight, 1);
    req = 4'b0;
    at(19); jtl_out = ~jtl_out; expect_ev(20, K_DONE, 2);
    at(20); check("infl0", inflight, 0);
    drain();

    // round robin, spacing, timeouts
    do_reset();
    req = 4'b1111;
    expect_ev(11, K_GNT, 1); expect_ev(14, K_GNT, 2);
    expect_ev(17, K_GNT, 4); expect_ev(20, K_GNT, 8);
    expect_ev(22, K_LATE, 0); expect_ev(23, K_GNT, 1);
    expect_ev(25, K_LATE, 0); expect_ev(28, K_LATE, 0);
    expect_ev(31, K_LATE, 0); expect_ev(34, K_LATE, 0);
    at(20); check("rr_full", inflight, 4);
    at(22); check("rr_pop", inflight, 3);
    check("sticky_late", err_sticky, 2);
    at(23); check("rr_refill", inflight, 4); req = 4'b0;
    at(35); check("rr_empty", inflight, 0); check("rr_idle", busy, 0);
    err_clr = 1'b1;
    at(36); err_clr = 1'b0; check("clr_late", err_sticky, 0);
    drain();

    // window edges, enable gating, dropped request
    do_reset();
    at(10); req = 4'b0001; expect_ev(11, K_GNT, 1);
    at(11); req = 4'b0;
    at(17); jtl_out = ~jtl_out; expect_ev(18, K_SPUR, 0);
    at(18); check("early_keep", inflight, 1);
    at(21); jtl_out = ~jtl_out; expect_ev(22, K_LATE, 0);
    at(22); check("late_pop", inflight, 0);
    at(23); req = 4'b0010; expect_ev(24, K_GNT, 2);
    at(24); req = 4'b0;
    at(31); jtl_out = ~jtl_out; expect_ev(32, K_DONE, 1);
    at(32); req = 4'b0100; expect_ev(33, K_GNT, 4);
    at(33); req = 4'b0;
    at(34); enable = 1'b0;
    at(35); req = 4'b1000;
    at(37); req = 4'b0;
    at(38); enable = 1'b1;
    at(42); jtl_out = ~jtl_out; expect_ev(43, K_DONE, 2);
    at(44); check("win_empty", inflight, 0);
    check("sticky_both", err_sticky, 3); err_clr = 1'b1;
    at(45); err_clr = 1'b0; check("clr_both", err_sticky, 0);
    at(46); jtl_out = ~jtl_out; expect_ev(47, K_SPUR, 0);
    at(47); check("sticky_spur", err_sticky, 1);
    at(48); err_clr = 1'b1;
    at(49); check("clr_spur", err_sticky, 0);
    jtl_out = ~jtl_out; expect_ev(50, K_SPUR, 0);
    at(50); err_clr = 1'b0; check("set_wins", err_sticky, 1);
    drain();

    // reset with pulses in flight
    do_reset();
    at(10); req = 4'b0111;
    expect_ev(11, K_GNT, 1); expect_ev(14, K_GNT, 2);
    expect_ev(17, K_GNT, 4);
    at(17); req = 4'b0;
    at(18); check("pre_rst", inflight, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_outs", int'({grant, jtl_in, done_valid,
          err_late, err_spurious, err_sticky, inflight}), 0);
    for (int c = 0; c < 10; c++) begin
      at(c);
      check("mid_quiet", busy, 1);
      if (c == 0 || c == 3 || c == 6) jtl_out = ~jtl_out;
      if (c == 5) req = 4'b0100;
    end
    at(10); check("mid_quiet_end", busy, 0);
    expect_ev(11, K_GNT, 4);
    at(11); req = 4'b0;
    at(19); jtl_out = ~jtl_out; expect_ev(20, K_DONE, 2);
    drain();

    // full FIFO with arrivals, push and pop together
    do_reset();
    req = 4'b1111;
    expect_ev(11, K_GNT, 1); expect_ev(14, K_GNT, 2);
    expect_ev(17, K_GNT, 4); expect_ev(20, K_GNT, 8);
    at(20); req = 4'b0; check("full", inflight, 4);
    jtl_out = ~jtl_out; expect_ev(21, K_DONE, 0);
    at(21); check("full_pop", inflight, 3);
    req = 4'b0001; expect_ev(23, K_GNT, 1);
    at(22); check("pre_pushpop", inflight, 3);
    jtl_out = ~jtl_out; expect_ev(23, K_DONE, 1);
    at(23); req = 4'b0; check("pushpop", inflight, 3);
    at(26); jtl_out = ~jtl_out; expect_ev(27, K_DONE, 2);
    expect_ev(31, K_LATE, 0);
    at(31); jtl_out = ~jtl_out; expect_ev(32, K_DONE, 0);
    at(33); check("final_empty", inflight, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
